// File: rtl/online_result_checker_r4_pkg.sv
// Shared definitions for the radix-4 signed-digit online adder result checker:
// checker FSM states, digit encoding constants and digit-range limits.
package online_r4_pkg;

  // Checker control states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RECV = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // 3-bit two's-complement code -4 is outside the redundant digit set
  localparam logic [2:0] DIGIT_ILLEGAL = 3'b100;

  // Each digit position weighs 4x the next lower one
  localparam int RADIX_LOG2 = 2;

  // Legal signed-digit range
  localparam int DIGIT_MIN = -3;
  localparam int DIGIT_MAX = 3;

endpackage

// File: rtl/online_result_checker_r4_if.sv
// Bundle of the checker's control, digit stream and report signals.
// master: the bench / vector source side; slave: the checker itself.
interface online_result_checker_r4_if #(
  parameter int N = 6,
  parameter int C = 3
);
  localparam int IW = $clog2(N + 2);
  localparam int DW = (N + 1) * C;
  localparam int VW = 2 * (N + 1) + 1;

  logic          start;
  logic [DW-1:0] exp_z;
  logic          z_valid;
  logic [C-1:0]  z_digit;
  logic          busy;
  logic          done;
  logic          pass;
  logic          timeout;
  logic          illegal;
  logic [IW-1:0] mismatch_idx;
  logic [DW-1:0] result;
  logic [VW-1:0] value;
  logic [7:0]    err_count;

  modport master (
    output start, exp_z, z_valid, z_digit,
    input  busy, done, pass, timeout, illegal, mismatch_idx, result, value, err_count
  );

  modport slave (
    input  start, exp_z, z_valid, z_digit,
    output busy, done, pass, timeout, illegal, mismatch_idx, result, value, err_count
  );

endinterface

// File: rtl/online_result_checker_r4_sd_accum.sv
// Signed-digit (radix 4) to two's-complement accumulator: every enabled
// cycle the running value is scaled by the radix and the new digit added.
module sd_accum_r4
  import online_r4_pkg::*;
#(
  parameter int C = 3,
  parameter int W = 15
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [C-1:0] digit_i,
  output logic [W-1:0] value_o
);

  logic [W-1:0] acc_q;
  logic [W-1:0] acc_d;

  // Next value: shift by one digit position and add the sign-extended digit
  always_comb begin
    acc_d = (acc_q << RADIX_LOG2) + {{(W - C){digit_i[C-1]}}, digit_i};
  end

  // Accumulator register; clear has priority over accumulate
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q <= '0;
    end else if (clr_i) begin
      acc_q <= '0;
    end else if (en_i) begin
      acc_q <= acc_d;
    end
  end

  assign value_o = acc_q;

endmodule

// File: rtl/online_result_checker_r4.sv
// Digit-serial checker for the radix-4 online adder result stream.
// Compares each incoming digit (MSD first) against a latched expected vector,
// detects illegal codes and inter-digit timeouts, and keeps a failure count.
// Optional feature macro: ONLINE_CHK_VALUE_EN builds the two's-complement
// value accumulator; without it the value output is tied to zero.
module online_result_checker_r4
  import online_r4_pkg::*;
#(
  parameter int N       = 6,
  parameter int C       = 3,
  parameter int TIMEOUT = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  online_result_checker_r4_if.slave  bus
);

  localparam int IW = $clog2(N + 2);
  localparam int DW = (N + 1) * C;
  localparam int VW = 2 * (N + 1) + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [IW-1:0] LAST_K    = IW'(N);
  localparam logic [IW-1:0] MISS_NONE = IW'(N + 1);
  localparam logic [TW-1:0] IDLE_LAST = TW'(TIMEOUT - 1);

  state_t state_q, state_d;

  logic [DW-1:0] exp_q;        // expected digits, shifted so the next one sits on top
  logic [DW-1:0] result_q;
  logic [IW-1:0] k_q;
  logic [TW-1:0] idle_q;
  logic          illegal_q;
  logic          timeout_q;
  logic          pass_q;
  logic          done_q;
  logic          miss_seen_q;
  logic [IW-1:0] miss_idx_q;
  logic [7:0]    err_q;
  logic [7:0]    err_d;
  logic          busy_d;

  logic start_ok;
  logic take;
  logic digit_bad;
  logic digit_illegal;
  logic last_digit;
  logic idle_expired;
  logic pass_now;
  logic finish_fail;

  // Per-cycle decode of the incoming digit and of the check's end conditions
  always_comb begin
    start_ok      = bus.start && (state_q != ST_RECV);
    take          = (state_q == ST_RECV) && bus.z_valid;
    digit_bad     = bus.z_digit != exp_q[DW-1 -: C];
    digit_illegal = bus.z_digit == DIGIT_ILLEGAL;
    last_digit    = take && (k_q == LAST_K);
    idle_expired  = (state_q == ST_RECV) && !bus.z_valid && (idle_q == IDLE_LAST);
    pass_now      = !(miss_seen_q || digit_bad) && !(illegal_q || digit_illegal);
    finish_fail   = idle_expired || (last_digit && !pass_now);
    err_d         = (finish_fail && (err_q != 8'hFF)) ? err_q + 8'd1 : err_q;
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: a check ends on the last digit or on an idle timeout
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (bus.start) state_d = ST_RECV;
      ST_RECV: if (last_digit || idle_expired) state_d = ST_DONE;
      ST_DONE: if (bus.start) state_d = ST_RECV;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy_d = (state_q == ST_RECV);
  end

  // Datapath: arm on start, then consume digits / count idle cycles in RECV
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exp_q       <= '0;
      result_q    <= '0;
      k_q         <= '0;
      idle_q      <= '0;
      illegal_q   <= 1'b0;
      timeout_q   <= 1'b0;
      pass_q      <= 1'b0;
      done_q      <= 1'b0;
      miss_seen_q <= 1'b0;
      miss_idx_q  <= MISS_NONE;
    end else begin
      done_q <= 1'b0;
      if (start_ok) begin
        exp_q       <= bus.exp_z;
        result_q    <= '0;
        k_q         <= '0;
        idle_q      <= '0;
        illegal_q   <= 1'b0;
        timeout_q   <= 1'b0;
        pass_q      <= 1'b0;
        miss_seen_q <= 1'b0;
        miss_idx_q  <= MISS_NONE;
      end else if (take) begin
        exp_q    <= exp_q << C;
        result_q <= {result_q[DW-C-1:0], bus.z_digit};
        k_q      <= k_q + IW'(1);
        idle_q   <= '0;
        if (digit_bad && !miss_seen_q) begin
          miss_seen_q <= 1'b1;
          miss_idx_q  <= k_q;
        end
        if (digit_illegal) begin
          illegal_q <= 1'b1;
        end
        if (last_digit) begin
          done_q <= 1'b1;
          pass_q <= pass_now;
        end
      end else if (state_q == ST_RECV) begin
        idle_q <= idle_q + TW'(1);
        if (idle_expired) begin
          timeout_q <= 1'b1;
          done_q    <= 1'b1;
          pass_q    <= 1'b0;
        end
      end
    end
  end

  // Failed-check counter, saturating
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= '0;
    end else begin
      err_q <= err_d;
    end
  end

`ifdef ONLINE_CHK_VALUE_EN
  logic [VW-1:0] value_w;

  sd_accum_r4 #(
    .C (C),
    .W (VW)
  ) u_accum (
    .clk     (clk),
    .reset   (reset),
    .clr_i   (start_ok),
    .en_i    (take),
    .digit_i (bus.z_digit),
    .value_o (value_w)
  );

  assign bus.value = value_w;
`else
  assign bus.value = '0;
`endif

  assign bus.busy         = busy_d;
  assign bus.done         = done_q;
  assign bus.pass         = pass_q;
  assign bus.timeout      = timeout_q;
  assign bus.illegal      = illegal_q;
  assign bus.mismatch_idx = miss_idx_q;
  assign bus.result       = result_q;
  assign bus.err_count    = err_q;

endmodule

// File: tb/tb_online_result_checker_r4.sv
// Self-checking bench for online_result_checker_r4: directed test-plan table,
// hand-written corner sequences and randomized streams against a digit-level
// arithmetic reference model.
module tb_online_result_checker_r4;
  import online_r4_pkg::*;

  localparam int N       = 6;
  localparam int C       = 3;
  localparam int TIMEOUT = 16;
  localparam int ND      = N + 1;
  localparam int DW      = ND * C;

`ifdef ONLINE_CHK_VALUE_EN
  localparam bit VAL_EN = 1'b1;
`else
  localparam bit VAL_EN = 1'b0;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b1;

  online_result_checker_r4_if #(.N(N), .C(C)) bus ();

  online_result_checker_r4 #(.N(N), .C(C), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks  = 0;
  int errors  = 0;
  int exp_err = 0;

  typedef struct {
    logic [DW-1:0] ex;
    logic [DW-1:0] rx;
    int            nsend;
    int            gap;
    bit            e_pass;
    int            e_midx;
    int            e_value;
    bit            e_to;
    bit            e_ill;
  } vec_t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string what, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", what, act, req);
    end
  endtask

  function automatic logic [DW-1:0] pk(input int d0, input int d1, input int d2, input int d3,
                                       input int d4, input int d5, input int d6);
    int d[7];
    logic [DW-1:0] r;
    d = '{d0, d1, d2, d3, d4, d5, d6};
    r = '0;
    for (int i = 0; i < ND; i++) r = (r << C) | DW'(d[i] & 7);
    return r;
  endfunction

  function automatic vec_t mk(input logic [DW-1:0] ex, input logic [DW-1:0] rx, input int nsend,
                              input int gap, input bit p, input int midx, input int val,
                              input bit to, input bit ill);
    vec_t v;
    v.ex = ex; v.rx = rx; v.nsend = nsend; v.gap = gap;
    v.e_pass = p; v.e_midx = midx; v.e_value = val; v.e_to = to; v.e_ill = ill;
    return v;
  endfunction

  // Reference model: positional arithmetic over the digits actually sent
  function automatic vec_t model(input logic [DW-1:0] ex, input logic [DW-1:0] rx,
                                 input int nsend, input int gap);
    vec_t v;
    v = mk(ex, rx, nsend, gap, 1'b0, ND, 0, 1'b0, 1'b0);
    for (int k = 0; k < nsend; k++) begin
      logic [C-1:0] rd;
      logic [C-1:0] ed;
      int d;
      int e;
      rd = rx[(ND-1-k)*C +: C];
      ed = ex[(ND-1-k)*C +: C];
      d  = int'($signed(rd));
      e  = int'($signed(ed));
      v.e_value = v.e_value * 4 + d;
      if (d == -4) v.e_ill = 1'b1;
      if (d != e && v.e_midx == ND) v.e_midx = k;
    end
    v.e_to   = (nsend < ND);
    v.e_pass = (v.e_midx == ND) && !v.e_ill && !v.e_to;
    return v;
  endfunction

  task automatic chk_reset(input string tag);
    chk({tag, " busy"}, bus.busy, 0);
    chk({tag, " done"}, bus.done, 0);
    chk({tag, " pass"}, bus.pass, 0);
    chk({tag, " timeout"}, bus.timeout, 0);
    chk({tag, " illegal"}, bus.illegal, 0);
    chk({tag, " mismatch_idx"}, bus.mismatch_idx, ND);
    chk({tag, " result"}, bus.result, 0);
    chk({tag, " value"}, bus.value, 0);
    chk({tag, " err_count"}, bus.err_count, 0);
  endtask

  task automatic start_check(input string tag, input logic [DW-1:0] ex);
    bus.exp_z = ex;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    bus.exp_z = ~ex;
    chk({tag, " busy_after_start"}, bus.busy, 1);
  endtask

  task automatic feed(input logic [DW-1:0] rx, input int nsend, input int gap);
    for (int k = 0; k < nsend; k++) begin
      bus.z_valid = 1'b1;
      bus.z_digit = rx[(ND-1-k)*C +: C];
      step();
      bus.z_valid = 1'b0;
      if (k < nsend - 1) repeat (gap) step();
    end
  endtask

  // Waits (bounded) for done and compares every report output once
  task automatic check_result(input string tag, input vec_t v);
    int waited;
    logic [DW-1:0] exp_res;
    waited = 0;
    while (bus.done !== 1'b1 && waited < 3 * TIMEOUT) begin
      step();
      waited++;
    end
    exp_res = v.rx >> ((ND - v.nsend) * C);
    if (!v.e_pass && exp_err < 255) exp_err++;
    chk({tag, " done_latency"}, waited, (v.nsend == ND) ? 0 : TIMEOUT);
    chk({tag, " done"}, bus.done, 1);
    chk({tag, " pass"}, bus.pass, v.e_pass);
    chk({tag, " mismatch_idx"}, bus.mismatch_idx, v.e_midx);
    chk({tag, " timeout"}, bus.timeout, v.e_to);
    chk({tag, " illegal"}, bus.illegal, v.e_ill);
    chk({tag, " value"}, longint'($signed(bus.value)), VAL_EN ? v.e_value : 0);
    chk({tag, " result"}, bus.result, exp_res);
    chk({tag, " err_count"}, bus.err_count, exp_err);
    $display("check %s: pass=%0b idx=%0d to=%0b ill=%0b value=%0d err=%0d", tag, bus.pass,
             bus.mismatch_idx, bus.timeout, bus.illegal, $signed(bus.value), bus.err_count);
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    start_check(tag, v.ex);
    feed(v.rx, v.nsend, v.gap);
    check_result(tag, v);
    step();
    chk({tag, " done_pulse_end"}, bus.done, 0);
    chk({tag, " busy_in_done"}, bus.busy, 0);
  endtask

  vec_t tbl[5];
  logic [DW-1:0] a_vec, b_vec, rnd_ex, rnd_rx;

  initial begin
    bus.start   = 1'b0;
    bus.exp_z   = '0;
    bus.z_valid = 1'b0;
    bus.z_digit = '0;

    // Directed test-plan vectors with hand-computed expectations
    tbl[0] = mk(pk(1, -1, 0, -1, 2, 2, 1), pk(1, -1, 0, -1, 2, 2, 1), 7, 0, 1'b1, 7, 3049, 1'b0, 1'b0);
    tbl[1] = mk(pk(0, 2, 2, 2, 2, 2, 2), pk(0, 2, 2, 2, 2, 2, 2), 7, 3, 1'b1, 7, 2730, 1'b0, 1'b0);
    tbl[2] = mk(pk(1, 3, 3, 3, 3, 3, 2), pk(1, 3, 2, 3, 3, 3, 2), 7, 0, 1'b0, 2, 7934, 1'b0, 1'b0);
    tbl[3] = mk(pk(1, 2, 3, -1, -2, -3, 0), pk(1, 2, 3, -1, -2, -3, 0), 4, 0, 1'b0, 7, 107, 1'b1, 1'b0);
    tbl[4] = mk(pk(0, 1, 1, 1, 1, 1, 1), pk(0, 1, -4, 1, 1, 1, 1), 7, 0, 1'b0, 2, 85, 1'b0, 1'b1);

    repeat (3) step();
    chk_reset("in_reset");
    reset = 1'b0;
    step();
    chk_reset("after_reset");

    for (int i = 0; i < 5; i++) run_vec($sformatf("table%0d", i), tbl[i]);

    // z_valid while not receiving must not disturb the held report
    bus.z_valid = 1'b1;
    bus.z_digit = 3'd3;
    repeat (3) step();
    bus.z_valid = 1'b0;
    chk("stray_valid result", bus.result, tbl[4].rx);
    chk("stray_valid done", bus.done, 0);
    chk("stray_valid busy", bus.busy, 0);

    // start raised during the done pulse re-arms immediately
    a_vec = tbl[0].ex;
    b_vec = pk(-3, 3, -2, 2, -1, 1, 0);
    start_check("back2back_a", a_vec);
    feed(a_vec, ND, 0);
    check_result("back2back_a", model(a_vec, a_vec, ND, 0));
    start_check("back2back_b", b_vec);
    feed(b_vec, ND, 0);
    check_result("back2back_b", model(b_vec, b_vec, ND, 0));
    step();

    // start during RECV is ignored
    start_check("start_in_recv", a_vec);
    for (int k = 0; k < ND; k++) begin
      bus.z_valid = 1'b1;
      bus.z_digit = a_vec[(ND-1-k)*C +: C];
      bus.start   = (k == 3);
      step();
    end
    bus.z_valid = 1'b0;
    bus.start   = 1'b0;
    check_result("start_in_recv", model(a_vec, a_vec, ND, 0));
    step();

    // Randomized streams against the reference model
    for (int i = 0; i < 30; i++) begin
      int r;
      int ns;
      rnd_ex = '0;
      for (int k = 0; k < ND; k++) begin
        int d;
        d = int'($urandom_range(DIGIT_MAX - DIGIT_MIN)) + DIGIT_MIN;
        rnd_ex = (rnd_ex << C) | DW'(d & 7);
      end
      rnd_rx = rnd_ex;
      r = int'($urandom_range(9));
      if (r < 4) begin
        int p;
        p = int'($urandom_range(ND - 1));
        rnd_rx[(ND-1-p)*C +: C] = 3'($urandom_range(7));
      end
      ns = (r == 9) ? int'($urandom_range(ND - 1, 1)) : ND;
      run_vec($sformatf("rand%0d", i), model(rnd_ex, rnd_rx, ns, int'($urandom_range(4))));
    end

    // Reset in the middle of a check
    start_check("midreset", a_vec);
    feed(a_vec, 3, 0);
    #2;
    reset = 1'b1;
    #1;
    chk_reset("midreset");
    step();
    reset   = 1'b0;
    exp_err = 0;
    step();
    run_vec("after_midreset", model(a_vec, a_vec, ND, 1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
